// File: rtl/dsp_file_pkg.sv
// Shared definitions for the DSP circular-buffer file reader/writer:
// descriptor layout, size encodings, status bits and sequencer states.
package dsp_file_pkg;

    localparam int unsigned FILE_STRIDE = 32'h20;

    localparam logic [7:0] OFF_START   = 8'h00;
    localparam logic [7:0] OFF_END     = 8'h04;
    localparam logic [7:0] OFF_RD_PTR  = 8'h08;
    localparam logic [7:0] OFF_WR_PTR  = 8'h0C;
    localparam logic [7:0] OFF_STATUS  = 8'h10;
    localparam logic [7:0] OFF_CONTROL = 8'h14;

    localparam logic [2:0] FLD_START   = 3'd0;
    localparam logic [2:0] FLD_END     = 3'd1;
    localparam logic [2:0] FLD_RD_PTR  = 3'd2;
    localparam logic [2:0] FLD_WR_PTR  = 3'd3;
    localparam logic [2:0] FLD_STATUS  = 3'd4;
    localparam logic [2:0] FLD_CONTROL = 3'd5;

    typedef enum logic [1:0] {
        SZ_UNDEF = 2'd0,
        SZ_BYTE  = 2'd1,
        SZ_HWORD = 2'd2,
        SZ_WORD  = 2'd3
    } size_e;

    localparam int unsigned ST_WRAP = 0;
    localparam int unsigned ST_FULL = 1;
    localparam int unsigned ST_ERR  = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_DATA_REQ,
        S_WR_DATA_WAIT,
        S_WR_STAT_REQ,
        S_WR_STAT_WAIT,
        S_WR_PTR_REQ,
        S_WR_PTR_WAIT,
        S_DONE
    } state_e;

    // Descriptor fields are consecutive words, so the offset is the field index * 4.
    function automatic logic [7:0] desc_offset(input logic [2:0] fld);
        return 8'({fld, 2'b00});
    endfunction

endpackage

// File: rtl/dsp_lane_sel.sv
// Byte-lane steering for one item store: lane enables, replicated write data
// and the pointer increment for the configured item size.
module dsp_lane_sel
    import dsp_file_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  ptr_i,
    input  logic [31:0] data_i,
    output logic [3:0]  sel_o,
    output logic [31:0] data_o,
    output logic [2:0]  inc_o
);

    always_comb begin
        sel_o  = '0;
        data_o = '0;
        inc_o  = '0;
        unique case (size_i)
            SZ_BYTE: begin
                sel_o  = 4'b0001 << ptr_i;
                data_o = {4{data_i[7:0]}};
                inc_o  = 3'd1;
            end
            SZ_HWORD: begin
                sel_o  = ptr_i[1] ? 4'hC : 4'h3;
                data_o = {2{data_i[15:0]}};
                inc_o  = 3'd2;
            end
            SZ_WORD: begin
                sel_o  = 4'hF;
                data_o = data_i;
                inc_o  = 3'd4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dsp_file_writer.sv
// Producer side of the DSP circular-buffer file: fetches a descriptor, stores one
// item at wr_ptr, then writes the updated status and wr_ptr back over the bus master.
module dsp_file_writer
    import dsp_file_pkg::*;
#(
    parameter int unsigned   dw       = 32,
    parameter int unsigned   aw       = 32,
    parameter logic [aw-1:0] RAM_BASE = '0
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [7:0]    file_num,
    input  logic          file_write,
    input  logic [31:0]   file_write_data,
    output logic          file_active,
    output logic          file_done,
    output logic          file_error,
    output logic [aw-1:0] address,
    output logic          start,
    output logic [3:0]    selection,
    output logic          write,
    output logic [dw-1:0] data_wr,
    input  logic [dw-1:0] data_rd,
    input  logic          active,
    output logic [31:0]   wr_ptr
);

    state_e        state_q, state_d;
    logic [2:0]    fld_q, fld_d;
    logic [aw-1:0] base_q, base_d;
    logic [31:0]   start_q, start_d;
    logic [31:0]   end_q, end_d;
    logic [31:0]   rdp_q, rdp_d;
    logic [31:0]   wrp_q, wrp_d;
    logic [31:0]   status_q, status_d;
    logic [31:0]   data_q, data_d;
    size_e         size_q, size_d;

    logic [3:0]    lane_sel;
    logic [31:0]   lane_data;
    logic [2:0]    inc;
    logic [31:0]   ptr_sum, ptr_new, status_new, rd32;
    logic          wrap;

    assign rd32   = data_rd[31:0];
    assign wr_ptr = wrp_q;

    dsp_lane_sel u_lane (
        .size_i (size_q),
        .ptr_i  (wrp_q[1:0]),
        .data_i (data_q),
        .sel_o  (lane_sel),
        .data_o (lane_data),
        .inc_o  (inc)
    );

    always_comb begin
        ptr_sum    = wrp_q + 32'(inc);
        wrap       = (ptr_sum > end_q);
        ptr_new    = wrp_q;
        status_new = status_q;
        if (size_q == SZ_UNDEF) begin
            status_new[ST_ERR] = 1'b1;
        end else begin
            ptr_new = wrap ? start_q : ptr_sum;
            if (wrap)              status_new[ST_WRAP] = 1'b1;
            if (ptr_new == rdp_q)  status_new[ST_FULL] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        fld_d    = fld_q;
        base_d   = base_q;
        start_d  = start_q;
        end_d    = end_q;
        rdp_d    = rdp_q;
        wrp_d    = wrp_q;
        status_d = status_q;
        data_d   = data_q;
        size_d   = size_q;

        address     = '0;
        start       = 1'b0;
        selection   = '0;
        write       = 1'b0;
        data_wr     = '0;
        file_active = (state_q != S_IDLE);
        file_done   = 1'b0;
        file_error  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (file_write) begin
                    base_d  = RAM_BASE + aw'(32'(file_num) * FILE_STRIDE);
                    data_d  = file_write_data;
                    fld_d   = '0;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ, S_RD_WAIT: begin
                address   = base_q + aw'(desc_offset(fld_q));
                selection = 4'hF;
                start     = (state_q == S_RD_REQ);
                if (state_q == S_RD_REQ) begin
                    if (active) state_d = S_RD_WAIT;
                end else if (!active) begin
                    unique case (fld_q)
                        FLD_START:   start_d  = rd32;
                        FLD_END:     end_d    = rd32;
                        FLD_RD_PTR:  rdp_d    = rd32;
                        FLD_WR_PTR:  wrp_d    = rd32;
                        FLD_STATUS:  status_d = rd32;
                        FLD_CONTROL: size_d   = size_e'(rd32[1:0]);
                        default: ;
                    endcase
                    if (fld_q == FLD_CONTROL) begin
                        state_d = (size_e'(rd32[1:0]) == SZ_UNDEF) ? S_WR_STAT_REQ : S_WR_DATA_REQ;
                    end else begin
                        fld_d   = fld_q + 3'd1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR_DATA_REQ, S_WR_DATA_WAIT: begin
                address   = aw'(wrp_q);
                selection = lane_sel;
                data_wr   = dw'(lane_data);
                write     = 1'b1;
                start     = (state_q == S_WR_DATA_REQ);
                if (state_q == S_WR_DATA_REQ) begin
                    if (active) state_d = S_WR_DATA_WAIT;
                end else if (!active) begin
                    state_d = S_WR_STAT_REQ;
                end
            end
            S_WR_STAT_REQ, S_WR_STAT_WAIT: begin
                address   = base_q + aw'(OFF_STATUS);
                selection = 4'hF;
                data_wr   = dw'(status_new);
                write     = 1'b1;
                start     = (state_q == S_WR_STAT_REQ);
                if (state_q == S_WR_STAT_REQ) begin
                    if (active) state_d = S_WR_STAT_WAIT;
                end else if (!active) begin
                    state_d = S_WR_PTR_REQ;
                end
            end
            S_WR_PTR_REQ, S_WR_PTR_WAIT: begin
                address   = base_q + aw'(OFF_WR_PTR);
                selection = 4'hF;
                data_wr   = dw'(ptr_new);
                write     = 1'b1;
                start     = (state_q == S_WR_PTR_REQ);
                if (state_q == S_WR_PTR_REQ) begin
                    if (active) state_d = S_WR_PTR_WAIT;
                end else if (!active) begin
                    // Pointer/status registers change only once the write-back has landed.
                    wrp_d    = ptr_new;
                    status_d = status_new;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                file_done  = 1'b1;
                file_error = (size_q == SZ_UNDEF);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q  <= S_IDLE;
            fld_q    <= '0;
            base_q   <= '0;
            start_q  <= '0;
            end_q    <= '0;
            rdp_q    <= '0;
            wrp_q    <= '0;
            status_q <= '0;
            data_q   <= '0;
            size_q   <= SZ_UNDEF;
        end else begin
            state_q  <= state_d;
            fld_q    <= fld_d;
            base_q   <= base_d;
            start_q  <= start_d;
            end_q    <= end_d;
            rdp_q    <= rdp_d;
            wrp_q    <= wrp_d;
            status_q <= status_d;
            data_q   <= data_d;
            size_q   <= size_d;
        end
    end

endmodule

// File: tb/tb_dsp_file_writer.sv
// Scoreboard bench for dsp_file_writer: a memory-backed bus slave checks each bus
// write and a done monitor checks wr_ptr/file_error against queued expectations.
module tb_dsp_file_writer;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] ptr;
        logic        err;
    } done_t;

    logic        wb_clk;
    logic        wb_rst_n;
    logic [7:0]  file_num;
    logic        file_write;
    logic [31:0] file_write_data;
    logic        file_active;
    logic        file_done;
    logic        file_error;
    logic [31:0] address;
    logic        start;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        active;
    logic [31:0] wr_ptr;

    logic [31:0] mem [256];
    wr_t         exp_wr[$];
    done_t       exp_done[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned nacc = 0;
    int unsigned nwr = 0;
    int unsigned start_viol = 0;
    int unsigned hold_cycles = 1;
    int unsigned busy = 0;
    int unsigned n0 = 0;
    int unsigned cyc = 0;

    dsp_file_writer #(.dw(32), .aw(32), .RAM_BASE(32'h0000_0000)) dut (
        .wb_clk          (wb_clk),
        .wb_rst_n        (wb_rst_n),
        .file_num        (file_num),
        .file_write      (file_write),
        .file_write_data (file_write_data),
        .file_active     (file_active),
        .file_done       (file_done),
        .file_error      (file_error),
        .address         (address),
        .start           (start),
        .selection       (selection),
        .write           (write),
        .data_wr         (data_wr),
        .data_rd         (data_rd),
        .active          (active),
        .wr_ptr          (wr_ptr)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " file_active"}, 32'(file_active), 32'h0);
        chk({tag, " file_done"},   32'(file_done),   32'h0);
        chk({tag, " file_error"},  32'(file_error),  32'h0);
        chk({tag, " address"},     address,          32'h0);
        chk({tag, " start"},       32'(start),       32'h0);
        chk({tag, " selection"},   32'(selection),   32'h0);
        chk({tag, " write"},       32'(write),       32'h0);
        chk({tag, " data_wr"},     data_wr,          32'h0);
        chk({tag, " wr_ptr"},      wr_ptr,           32'h0);
    endtask

    task automatic exp_w(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.sel  = s;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic exp_d(input logic [31:0] p, input logic er);
        done_t e;
        e.ptr = p;
        e.err = er;
        exp_done.push_back(e);
    endtask

    task automatic set_desc(input int unsigned fn, input logic [31:0] st, input logic [31:0] en,
                            input logic [31:0] rd, input logic [31:0] wr,
                            input logic [31:0] status, input logic [31:0] ctrl);
        mem[fn*8 + 0] = st;
        mem[fn*8 + 1] = en;
        mem[fn*8 + 2] = rd;
        mem[fn*8 + 3] = wr;
        mem[fn*8 + 4] = status;
        mem[fn*8 + 5] = ctrl;
    endtask

    task automatic run_op(input string tag, input logic [7:0] fn, input logic [31:0] d,
                          input int unsigned hold);
        int unsigned c;
        hold_cycles = hold;
        @(negedge wb_clk);
        file_num        = fn;
        file_write_data = d;
        file_write      = 1'b1;
        @(negedge wb_clk);
        file_write = 1'b0;
        c = 0;
        while (!file_done && c < 2000) begin
            @(negedge wb_clk);
            c++;
        end
        chk({tag, " done before timeout"}, 32'(c < 2000), 32'h1);
        @(negedge wb_clk);
        chk({tag, " back to idle"}, 32'(file_active), 32'h0);
    endtask

    // Bus slave: accepts on start while idle, holds active for hold_cycles, scoreboards writes.
    initial begin
        wr_t e;
        active  = 1'b0;
        data_rd = '0;
        forever begin
            @(negedge wb_clk);
            if (!wb_rst_n) begin
                active = 1'b0;
                busy   = 0;
            end else if (active) begin
                if (start) start_viol++;
                if (busy > 1) busy--;
                else begin
                    active = 1'b0;
                    busy   = 0;
                end
            end else if (start) begin
                nacc++;
                if (write) begin
                    nwr++;
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL bus_write unexpected: addr %h sel %h data %h", address, selection, data_wr);
                    end else begin
                        e = exp_wr.pop_front();
                        if (address !== e.addr || selection !== e.sel || data_wr !== e.data) begin
                            errors++;
                            $display("FAIL bus_write: got addr %h sel %h data %h expected addr %h sel %h data %h",
                                     address, selection, data_wr, e.addr, e.sel, e.data);
                        end
                    end
                    for (int i = 0; i < 4; i++)
                        if (selection[i]) mem[address[9:2]][8*i +: 8] = data_wr[8*i +: 8];
                end else begin
                    data_rd = mem[address[9:2]];
                end
                active = 1'b1;
                busy   = hold_cycles;
            end
        end
    end

    // Done monitor.
    initial begin
        done_t e;
        forever begin
            @(negedge wb_clk);
            if (wb_rst_n && file_done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done unexpected: wr_ptr %h err %b", wr_ptr, file_error);
                end else begin
                    e = exp_done.pop_front();
                    if (wr_ptr !== e.ptr || file_error !== e.err || file_active !== 1'b1) begin
                        errors++;
                        $display("FAIL done: got wr_ptr %h err %b active %b expected wr_ptr %h err %b active 1",
                                 wr_ptr, file_error, file_active, e.ptr, e.err);
                    end
                end
            end else if (wb_rst_n && file_error) begin
                checks++;
                errors++;
                $display("FAIL file_error: got 1 without file_done expected 0");
            end
        end
    end

    logic [31:0] t3_addr [4] = '{32'h101, 32'h102, 32'h103, 32'h100};
    logic [3:0]  t3_sel  [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
    logic [7:0]  t3_byte [4] = '{8'hA5, 8'hA6, 8'hA7, 8'hA8};
    logic [31:0] t3_ptr  [4] = '{32'h102, 32'h103, 32'h100, 32'h101};
    logic [31:0] t3_stat [4] = '{32'h0, 32'h0, 32'h3, 32'h3};
    logic [31:0] t3_mem  [4] = '{32'h1122A544, 32'h11A6A544, 32'hA7A6A544, 32'hA7A6A5A8};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        wb_rst_n        = 1'b0;
        file_write      = 1'b0;
        file_num        = '0;
        file_write_data = '0;
        repeat (3) @(negedge wb_clk);
        chk_idle("reset");
        wb_rst_n = 1'b1;
        repeat (2) @(negedge wb_clk);

        // 1: plain word store
        set_desc(0, 32'h100, 32'h10C, 32'h100, 32'h104, 32'h0, 32'h3);
        exp_w(32'h104, 4'hF, 32'hDEADBEEF);
        exp_w(32'h010, 4'hF, 32'h0);
        exp_w(32'h00C, 4'hF, 32'h108);
        exp_d(32'h108, 1'b0);
        n0 = nacc;
        run_op("t1", 8'd0, 32'hDEADBEEF, 1);
        chk("t1 accesses", nacc - n0, 32'd9);
        chk("t1 mem data", mem[32'h104 >> 2], 32'hDEADBEEF);
        chk("t1 mem wr_ptr", mem[3], 32'h108);

        // 2: wrap onto rd_ptr sets WRAP and FULL
        set_desc(1, 32'h100, 32'h10C, 32'h100, 32'h10C, 32'h0, 32'h3);
        exp_w(32'h10C, 4'hF, 32'hCAFEF00D);
        exp_w(32'h030, 4'hF, 32'h3);
        exp_w(32'h02C, 4'hF, 32'h100);
        exp_d(32'h100, 1'b0);
        run_op("t2", 8'd1, 32'hCAFEF00D, 1);
        chk("t2 mem data", mem[32'h10C >> 2], 32'hCAFEF00D);
        chk("t2 mem status", mem[12], 32'h3);

        // 3: byte lanes with wrap, upper data bits must be ignored
        set_desc(2, 32'h100, 32'h103, 32'h100, 32'h101, 32'h0, 32'h1);
        mem[32'h100 >> 2] = 32'h11223344;
        for (int i = 0; i < 4; i++) begin
            exp_w(t3_addr[i], t3_sel[i], {4{t3_byte[i]}});
            exp_w(32'h050, 4'hF, t3_stat[i]);
            exp_w(32'h04C, 4'hF, t3_ptr[i]);
            exp_d(t3_ptr[i], 1'b0);
            run_op("t3", 8'd2, {24'h5A5A5A, t3_byte[i]}, 1);
            chk("t3 mem word", mem[32'h100 >> 2], t3_mem[i]);
        end

        // 4: undefined size skips the data write and flags ERR
        set_desc(3, 32'h200, 32'h2FC, 32'h200, 32'h210, 32'h0, 32'h4);
        mem[32'h210 >> 2] = 32'h55555555;
        exp_w(32'h070, 4'hF, 32'h4);
        exp_w(32'h06C, 4'hF, 32'h210);
        exp_d(32'h210, 1'b1);
        n0 = nacc;
        run_op("t4", 8'd3, 32'h12345678, 1);
        chk("t4 accesses", nacc - n0, 32'd8);
        chk("t4 mem untouched", mem[32'h210 >> 2], 32'h55555555);

        // 5: stalled bus
        set_desc(4, 32'h100, 32'h10C, 32'h100, 32'h104, 32'h0, 32'h3);
        mem[32'h104 >> 2] = 32'h0;
        exp_w(32'h104, 4'hF, 32'hDEADBEEF);
        exp_w(32'h090, 4'hF, 32'h0);
        exp_w(32'h08C, 4'hF, 32'h108);
        exp_d(32'h108, 1'b0);
        n0 = nacc;
        run_op("t5", 8'd4, 32'hDEADBEEF, 5);
        chk("t5 accesses", nacc - n0, 32'd9);
        chk("t5 start while active", start_viol, 32'd0);
        chk("t5 mem data", mem[32'h104 >> 2], 32'hDEADBEEF);

        // 6: reset while the data write is outstanding, then a clean rerun
        set_desc(5, 32'h100, 32'h10C, 32'h100, 32'h104, 32'h0, 32'h3);
        mem[32'h104 >> 2] = 32'h0;
        exp_w(32'h104, 4'hF, 32'hDEADBEEF);
        hold_cycles = 5;
        n0 = nwr;
        @(negedge wb_clk);
        file_num        = 8'd5;
        file_write_data = 32'hDEADBEEF;
        file_write      = 1'b1;
        @(negedge wb_clk);
        file_write = 1'b0;
        cyc = 0;
        while (nwr == n0 && cyc < 500) begin
            @(negedge wb_clk);
            cyc++;
        end
        chk("t6 reached data write", 32'(cyc < 500), 32'h1);
        @(posedge wb_clk);
        #1;
        chk("t6 in write wait start", 32'(start), 32'h0);
        chk("t6 in write wait write", 32'(write), 32'h1);
        @(negedge wb_clk);
        wb_rst_n = 1'b0;
        @(posedge wb_clk);
        #1;
        chk_idle("t6 reset");
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        repeat (2) @(negedge wb_clk);
        exp_w(32'h104, 4'hF, 32'hDEADBEEF);
        exp_w(32'h0B0, 4'hF, 32'h0);
        exp_w(32'h0AC, 4'hF, 32'h108);
        exp_d(32'h108, 1'b0);
        run_op("t6 rerun", 8'd5, 32'hDEADBEEF, 1);
        chk("t6 mem wr_ptr", mem[5*8 + 3], 32'h108);

        repeat (3) @(negedge wb_clk);
        chk("pending bus writes", exp_wr.size(), 32'd0);
        chk("pending done events", exp_done.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
